// File: rtl/axis_dispatch_pkg.sv
// rtl/axis_dispatch_pkg.sv - shared types and helpers for the packet dispatcher
package axis_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } disp_state_e;

  localparam int DROP_CNT_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_dispatch_oreg.sv
// rtl/axis_dispatch_oreg.sv - single registered output stage holding the beat and its route
module axis_dispatch_oreg
  import axis_dispatch_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int USIZE = 1,
  parameter int SEL_W = 2,
  parameter int KW    = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_load,
  input  logic             i_sel_upd,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [DSIZE-1:0] i_tdata,
  input  logic [KW-1:0]    i_tkeep,
  input  logic [USIZE-1:0] i_tuser,
  input  logic             i_tlast,
  input  logic [NUM-1:0]   i_tready,
  output logic [DSIZE-1:0] o_tdata,
  output logic [KW-1:0]    o_tkeep,
  output logic [USIZE-1:0] o_tuser,
  output logic             o_tlast,
  output logic [NUM-1:0]   o_tvalid,
  output logic             o_ovld,
  output logic             o_rdy
);

  logic             r_ovld;
  logic [SEL_W-1:0] r_sel;
  logic [DSIZE-1:0] r_tdata;
  logic [KW-1:0]    r_tkeep;
  logic [USIZE-1:0] r_tuser;
  logic             r_tlast;

  // i_load is only raised when the held beat is gone or leaving this cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovld  <= 1'b0;
      r_sel   <= '0;
      r_tdata <= '0;
      r_tkeep <= '0;
      r_tuser <= '0;
      r_tlast <= 1'b0;
    end else if (i_load) begin
      r_ovld  <= 1'b1;
      r_tdata <= i_tdata;
      r_tkeep <= i_tkeep;
      r_tuser <= i_tuser;
      r_tlast <= i_tlast;
      if (i_sel_upd) r_sel <= i_sel;
    end else if (o_rdy) begin
      r_ovld <= 1'b0;
    end
  end

  always_comb begin
    o_tvalid = '0;
    for (int i = 0; i < NUM; i++) o_tvalid[i] = r_ovld && (r_sel == SEL_W'(i));
  end

  assign o_rdy   = i_tready[r_sel];
  assign o_ovld  = r_ovld;
  assign o_tdata = r_tdata;
  assign o_tkeep = r_tkeep;
  assign o_tuser = r_tuser;
  assign o_tlast = r_tlast;

endmodule

// File: rtl/axis_packet_dispatch_s2m.sv
// rtl/axis_packet_dispatch_s2m.sv - packet-level one-to-many AXIS dispatcher (route latched per packet)
// Optional AXIS_DISPATCH_DROP_EN: out-of-range destinations are consumed and counted instead of routed.
module axis_packet_dispatch_s2m
  import axis_dispatch_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int DSIZE  = 8,
  parameter int USIZE  = 1,
  parameter int DEST_W = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DSIZE-1:0]      s_tdata,
  input  logic [DSIZE/8-1:0]    s_tkeep,
  input  logic [USIZE-1:0]      s_tuser,
  input  logic [DEST_W-1:0]     s_tdest,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DSIZE-1:0]      m_tdata,
  output logic [DSIZE/8-1:0]    m_tkeep,
  output logic [USIZE-1:0]      m_tuser,
  output logic                  m_tlast,
  output logic [NUM-1:0]        m_tvalid,
  input  logic [NUM-1:0]        m_tready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int SEL_W = clog2(NUM);
  localparam int KW    = DSIZE / 8;

  disp_state_e      r_state;
  disp_state_e      w_state_nxt;
  logic             w_ovld;
  logic             w_rdy;
  logic             w_accept;
  logic             w_load;
  logic             w_sel_upd;
  logic             w_dest_oor;
  logic             w_drop_first;
  logic [SEL_W-1:0] w_sel_dec;

  assign w_dest_oor = (32'(s_tdest) >= 32'(NUM));
  assign w_sel_dec  = w_dest_oor ? SEL_W'(NUM - 1) : SEL_W'(s_tdest);

`ifdef AXIS_DISPATCH_DROP_EN
  assign w_drop_first = w_dest_oor;
`else
  assign w_drop_first = 1'b0;
`endif

  // While dropping, the input never waits on the output stage
  assign s_tready = aresetn && ((r_state == DROP) || !w_ovld || w_rdy);
  assign w_accept = s_tvalid && s_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_sel_upd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load    = !w_drop_first;
          w_sel_upd = !w_drop_first;
          if (!s_tlast) w_state_nxt = w_drop_first ? DROP : BUSY;
        end
      end
      BUSY: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_tlast) w_state_nxt = IDLE;
        end
      end
      DROP: begin
        if (w_accept && s_tlast) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef AXIS_DISPATCH_DROP_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_cnt <= '0;
    end else if (w_accept && s_tlast && r_drop_cnt != '1 &&
                 ((r_state == DROP) || (r_state == IDLE && w_drop_first))) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  axis_dispatch_oreg #(
    .NUM   (NUM),
    .DSIZE (DSIZE),
    .USIZE (USIZE),
    .SEL_W (SEL_W),
    .KW    (KW)
  ) u_oreg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_load    (w_load),
    .i_sel_upd (w_sel_upd),
    .i_sel     (w_sel_dec),
    .i_tdata   (s_tdata),
    .i_tkeep   (s_tkeep),
    .i_tuser   (s_tuser),
    .i_tlast   (s_tlast),
    .i_tready  (m_tready),
    .o_tdata   (m_tdata),
    .o_tkeep   (m_tkeep),
    .o_tuser   (m_tuser),
    .o_tlast   (m_tlast),
    .o_tvalid  (m_tvalid),
    .o_ovld    (w_ovld),
    .o_rdy     (w_rdy)
  );

endmodule
